// File: rtl/tx_srrc_pkg.sv
// Shared constants for the 4-ASK SRRC pulse shaper: coefficient set, level codes, defaults.
// Also used by the receive-side bench as the golden coefficient source.
package tx_srrc_pkg;

    localparam int TAPS_DEF = 21;
    localparam int OSR_DEF  = 4;
    localparam int COEF_W   = 18;
    localparam int PROD_W   = 20;
    localparam int NCOEF    = (TAPS_DEF + 1) / 2;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Half of the symmetric impulse response, 1s17; the last entry is the centre tap.
    localparam coef_t SRRC_COEF [NCOEF] = '{
        18'sd2817,  18'sd4060,  18'sd2289,  -18'sd2373, -18'sd7348, -18'sd8574,
        -18'sd2772, 18'sd10263, 18'sd26830, 18'sd40696, 18'sd46096
    };

    typedef enum logic [1:0] {
        LVL_M3 = 2'b00,
        LVL_M1 = 2'b01,
        LVL_P1 = 2'b10,
        LVL_P3 = 2'b11
    } level_t;

    typedef struct packed {
        logic   valid;
        level_t sym;
    } tap_entry_t;

    // Folds a tap position onto the stored half of a symmetric filter.
    function automatic int coef_index(input int k, input int taps);
        return (k < taps - 1 - k) ? k : taps - 1 - k;
    endfunction

endpackage

// File: rtl/tx_level_scale.sv
// Multiplier-free tap product: coefficient scaled by a 4-ASK level using only shifts and one add.
// The negative levels reuse the positive magnitude so the response is exactly odd in level.
module tx_level_scale
    import tx_srrc_pkg::*;
(
    input  tap_entry_t                 entry,
    input  coef_t                      coef,
    output logic signed [PROD_W-1:0]   prod
);

    logic signed [PROD_W-1:0] c_ext;
    logic signed [PROD_W-1:0] quarter;
    logic signed [PROD_W-1:0] half;
    logic signed [PROD_W-1:0] mag;
    logic                     positive;

    assign c_ext    = {{(PROD_W - COEF_W){coef[COEF_W-1]}}, coef};
    assign quarter  = c_ext >>> 2;
    assign half     = c_ext >>> 1;
    assign positive = (entry.sym == LVL_P1) || (entry.sym == LVL_P3);

    always_comb begin
        mag = quarter;
        if ((entry.sym == LVL_P3) || (entry.sym == LVL_M3)) begin
            mag = quarter + half;
        end
    end

    always_comb begin
        prod = '0;
        if (entry.valid) begin
            prod = positive ? mag : -mag;
        end
    end

endmodule

// File: rtl/tx_srrc_upsample_filter.sv
// Transmit pulse shaper: 4-ASK symbols captured once per OSR clocks, zero-stuffed, and filtered
// by a symmetric SRRC built from shift-add tap products; output is registered 1s17.
module tx_srrc_upsample_filter
    import tx_srrc_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int OSR    = OSR_DEF,
    parameter int ACC_W  = 22,
    parameter int DATA_W = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sym_en,
    input  logic [1:0]               symbol_in,
    output logic                     sym_stb,
    output logic signed [DATA_W-1:0] y
);

    localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    logic [CNT_W-1:0]          cnt;
    logic                      strobe;
    tap_entry_t                d_p0   [TAPS];
    logic signed [PROD_W-1:0]  prod_p0 [TAPS];
    logic signed [ACC_W-1:0]   acc_p0;
    logic signed [DATA_W-1:0]  y_p1;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX) begin
            return {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (a < SAT_MIN) begin
            return {1'b1, {(DATA_W - 1){1'b0}}};
        end
        return a[DATA_W-1:0];
    endfunction

    assign strobe  = (cnt == '0);
    assign sym_stb = strobe & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(OSR - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Stage p0: zero-stuffing delay line; only strobe slots load a (possibly idle) symbol.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                d_p0[k] <= '0;
            end
        end else begin
            d_p0[0] <= strobe ? tap_entry_t'({sym_en, symbol_in}) : tap_entry_t'('0);
            for (int k = 1; k < TAPS; k++) begin
                d_p0[k] <= d_p0[k-1];
            end
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        tx_level_scale u_scale (
            .entry (d_p0[k]),
            .coef  (SRRC_COEF[coef_index(k, TAPS)]),
            .prod  (prod_p0[k])
        );
    end

    always_comb begin
        acc_p0 = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc_p0 = acc_p0 + sext_prod(prod_p0[k]);
        end
    end

    // Stage p1: saturated output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_p1 <= '0;
        end else begin
            y_p1 <= sat_out(acc_p0);
        end
    end

    assign y = y_p1;

endmodule

// File: tb/tb_tx_srrc_upsample_filter.sv
// Self-checking bench for tx_srrc_upsample_filter: directed impulses, steady-state stream,
// strobe timing, mid-stream reset and a long random run against a convolution reference.
module tb_tx_srrc_upsample_filter;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               sym_en = 1'b0;
    logic [1:0]         symbol_in = 2'b00;
    logic               sym_stb;
    logic signed [17:0] y;

    int checks = 0;
    int errors = 0;

    int b_tab [11] = '{2817, 4060, 2289, -2373, -7348, -8574, -2772, 10263, 26830, 40696, 46096};

    // hist[0] = sample taken at the latest edge, hist[j] = sample j edges earlier.
    int hist [22];
    int edge_n;
    int y_s;
    int max_abs = 0;
    int resp [4][25];

    always #5 clk = ~clk;

    tx_srrc_upsample_filter dut (
        .clk       (clk),
        .reset     (reset),
        .sym_en    (sym_en),
        .symbol_in (symbol_in),
        .sym_stb   (sym_stb),
        .y         (y)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lvl_of(input logic [1:0] s);
        case (s)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b10:   return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int tap_p(input int lvl, input int k);
        int c;
        int mag;
        c = b_tab[(k <= 10) ? k : 20 - k];
        if (lvl == 0) return 0;
        mag = (lvl == 3 || lvl == -3) ? (c >>> 2) + (c >>> 1) : (c >>> 2);
        return (lvl > 0) ? mag : -mag;
    endfunction

    function automatic int model_raw();
        int s;
        s = 0;
        for (int k = 0; k < 21; k++) s += tap_p(hist[k+1], k);
        return s;
    endfunction

    function automatic int clamp18(input int v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    task automatic clear_model();
        for (int j = 0; j < 22; j++) hist[j] = 0;
        edge_n = 0;
    endtask

    // One clock: drive at the falling edge, check strobe, advance the model, check y after the edge.
    task automatic step(input logic en, input logic [1:0] s);
        int raw;
        @(negedge clk);
        sym_en    = en;
        symbol_in = s;
        check_val("sym_stb", int'(sym_stb), int'(edge_n % 4 == 0));
        @(posedge clk);
        for (int j = 21; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = ((edge_n % 4 == 0) && en) ? lvl_of(s) : 0;
        edge_n++;
        #1;
        raw = model_raw();
        if (raw > max_abs) max_abs = raw;
        if (-raw > max_abs) max_abs = -raw;
        y_s = int'(y);
        check_val("y", y_s, clamp18(raw));
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        check_val("rst_y_async", int'(y), 0);
        check_val("rst_stb", int'(sym_stb), 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_y_hold", int'(y), 0);
        check_val("rst_stb_hold", int'(sym_stb), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        clear_model();
    endtask

    task automatic impulse(input logic [1:0] s);
        do_reset();
        step(1'b1, s);
        resp[s][0] = y_s;
        for (int i = 1; i < 25; i++) begin
            step(1'b0, 2'($urandom));
            resp[s][i] = y_s;
        end
    endtask

    initial begin
        clear_model();
        do_reset();

        impulse(2'b11);
        check_val("imp_p3_e1", resp[3][1], 2112);
        check_val("imp_p3_e11", resp[3][11], 34572);
        check_val("imp_p3_e21", resp[3][21], 2112);
        check_val("imp_p3_e22", resp[3][22], 0);
        check_val("imp_p3_e24", resp[3][24], 0);
        impulse(2'b10);
        check_val("imp_p1_e11", resp[2][11], 11524);
        impulse(2'b01);
        check_val("imp_m1_e11", resp[1][11], -11524);
        impulse(2'b00);
        check_val("imp_m3_e11", resp[0][11], -34572);
        for (int i = 0; i < 25; i++) begin
            check_val("neg_m3", resp[0][i], -resp[3][i]);
            check_val("neg_m1", resp[1][i], -resp[2][i]);
        end

        do_reset();
        for (int i = 0; i < 48; i++) begin
            step(1'b1, 2'b11);
            if (i == 41 || i == 45) check_val("steady_p3", y_s, 33446);
        end

        // Strobe slots carry a fixed symbol; every other slot toggles symbol_in/sym_en randomly.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            if (i % 4 == 0) step(1'b1, 2'b10);
            else step(1'($urandom), 2'($urandom));
        end

        do_reset();
        for (int i = 0; i < 8000; i++) begin
            step(1'($urandom_range(7) != 0), 2'($urandom));
            if (i == 3002) do_reset();
        end
        check_val("no_sat", int'(max_abs <= 131071), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
